// File: rtl/alu_md_control_pkg.sv
// Shared ALU op codes, control-unit class codes, RV32M funct3 codes and sequencer states.
// Imported by the ALU, the main control unit and the multiply/divide sequencer.
package alu_md_control_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [2:0] ALUOP_R = 3'b000;
    localparam logic [2:0] ALUOP_I = 3'b001;
    localparam logic [2:0] ALUOP_U = 3'b100;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    function automatic logic m_rs1_signed(input logic [2:0] f3);
        return (f3 == M_MULH) || (f3 == M_MULHSU) || (f3 == M_DIV) || (f3 == M_REM);
    endfunction

    function automatic logic m_rs2_signed(input logic [2:0] f3);
        return (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
    endfunction

endpackage

// File: rtl/alu_md_control_md_iter_unit.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand magnitudes, one bit per cycle.
// Latency: XLEN+1 cycles from start to done, 1 cycle for divide-by-zero and signed overflow.
// Backpressure: none; start_i is only honoured in IDLE, operands are ignored while iterating.
module md_iter_unit
    import alu_md_control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            idle_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sa_in, sb_in, div_by_zero, div_ovf, last;
    logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   mul_res, div_res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        sa_in       = m_rs1_signed(funct3_i) & rs1_i[XLEN-1];
        sb_in       = m_rs2_signed(funct3_i) & rs2_i[XLEN-1];
        mag_a       = sa_in ? -rs1_i : rs1_i;
        mag_b       = sb_in ? -rs2_i : rs2_i;
        div_by_zero = (rs2_i == '0);
        div_ovf     = ((funct3_i == M_DIV) || (funct3_i == M_REM)) &&
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        last        = (cnt_q == CW'(XLEN-1));

        // acc holds {partial product, remaining multiplier bits} while multiplying
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opa_q : '0)};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = (sa_q ^ sb_q) ? -mul_next : mul_next;
        mul_res  = (f3_q == M_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

        // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opa_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
        quo       = div_next[XLEN-1:0];
        rem       = div_next[2*XLEN-1:XLEN];
        div_res   = f3_q[1] ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quo : quo);

        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    f3_d  = funct3_i;
                    sa_d  = sa_in;
                    sb_d  = sb_in;
                    cnt_d = '0;
                    if (funct3_i[2]) begin
                        if (div_by_zero) begin
                            result_d = funct3_i[1] ? rs1_i : '1;
                            state_d  = MD_DONE;
                        end else if (div_ovf) begin
                            result_d = funct3_i[1] ? '0 : rs1_i;
                            state_d  = MD_DONE;
                        end else begin
                            opa_d   = mag_b;
                            acc_d   = {{XLEN{1'b0}}, mag_a};
                            state_d = MD_DIV;
                        end
                    end else begin
                        opa_d   = mag_a;
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                        state_d = MD_MUL;
                    end
                end
            end
            MD_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    result_d = mul_res;
                    state_d  = MD_DONE;
                end
            end
            MD_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    result_d = div_res;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            acc_q    <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    assign idle_o   = (state_q == MD_IDLE);
    assign busy_o   = (state_q == MD_MUL) || (state_q == MD_DIV);
    assign done_o   = (state_q == MD_DONE);
    assign result_o = result_q;

endmodule

// File: rtl/alu_md_control.sv
// RV32IM ALU control: combinational ALU op decode plus iterative multiply/divide with PC/RF stall.
// Latency: decode 0 cycles; M ops done XLEN+1 cycles after acceptance (1 for div-by-zero/overflow).
// Backpressure: md_stall_o freezes PC and RF write from the decode cycle until the done cycle.
module alu_md_control
    import alu_md_control_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      ALU_Op_i,
    input  logic [2:0]      funct3_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [3:0]      ALU_Operation_o,
    output logic            md_stall_o,
    output logic            md_done_o,
    output logic [XLEN-1:0] md_result_o,
    output logic            result_sel_o
);

    logic            m_op, md_start, md_idle, md_busy, md_done;
    logic [XLEN-1:0] md_result;

    always_comb begin
        ALU_Operation_o = ALU_ADD;
        case (ALU_Op_i)
            ALUOP_R: begin
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        3'b000:  ALU_Operation_o = ALU_ADD;
                        3'b001:  ALU_Operation_o = ALU_SLL;
                        3'b010:  ALU_Operation_o = ALU_SLT;
                        3'b011:  ALU_Operation_o = ALU_SLTU;
                        3'b100:  ALU_Operation_o = ALU_XOR;
                        3'b101:  ALU_Operation_o = ALU_SRL;
                        3'b110:  ALU_Operation_o = ALU_OR;
                        default: ALU_Operation_o = ALU_AND;
                    endcase
                end else if (funct7_i == F7_ALT) begin
                    if (funct3_i == 3'b000) begin
                        ALU_Operation_o = ALU_SUB;
                    end else if (funct3_i == 3'b101) begin
                        ALU_Operation_o = ALU_SRA;
                    end
                end
            end
            ALUOP_I: begin
                case (funct3_i)
                    3'b000:  ALU_Operation_o = ALU_ADD;
                    3'b010:  ALU_Operation_o = ALU_SLT;
                    3'b011:  ALU_Operation_o = ALU_SLTU;
                    3'b100:  ALU_Operation_o = ALU_XOR;
                    3'b110:  ALU_Operation_o = ALU_OR;
                    3'b111:  ALU_Operation_o = ALU_AND;
                    3'b001: begin
                        if (funct7_i == F7_BASE) ALU_Operation_o = ALU_SLL;
                    end
                    default: begin
                        if (funct7_i == F7_BASE) begin
                            ALU_Operation_o = ALU_SRL;
                        end else if (funct7_i == F7_ALT) begin
                            ALU_Operation_o = ALU_SRA;
                        end
                    end
                endcase
            end
            ALUOP_U: ALU_Operation_o = ALU_LUI;
            default: ALU_Operation_o = ALU_ADD;
        endcase
    end

    assign m_op     = ENABLE_M && (ALU_Op_i == ALUOP_R) && (funct7_i == F7_MULDIV);
    assign md_start = valid_i & m_op;

    generate
        if (ENABLE_M) begin : g_md
            md_iter_unit #(
                .XLEN(XLEN)
            ) u_md_iter_unit (
                .clk      (clk),
                .reset    (reset),
                .start_i  (md_start),
                .funct3_i (funct3_i),
                .rs1_i    (rs1_data_i),
                .rs2_i    (rs2_data_i),
                .idle_o   (md_idle),
                .busy_o   (md_busy),
                .done_o   (md_done),
                .result_o (md_result)
            );
        end else begin : g_no_md
            assign md_idle   = 1'b1;
            assign md_busy   = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    // Stall is combinational so the decode cycle itself is frozen; DONE releases it for write-back.
    assign md_stall_o   = (md_idle & md_start) | md_busy;
    assign md_done_o    = md_done;
    assign result_sel_o = md_done;
    assign md_result_o  = md_result;

endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
Second-generation ALU control for the single-cycle RV32 core. It keeps the combinational R/I/U-type ALU operation decode, widened to the full RV32I ALU set. It adds an iterative RV32M multiply/divide sequencer with a stall handshake to the PC/register-file write logic. It sits between the main control unit, the instruction fields and the register-file read ports, alongside the existing ALU.

Parameters:
XLEN, 32, operand and result width.
ENABLE_M, 1, when 0: M-extension instructions decode as ADD and never stall; sequencer tied off.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
funct7_i  input  7  instruction[31:25]
ALU_Op_i  input  3  class from control unit: 000 R, 001 I, 100 U (LUI); others reserved
funct3_i  input  3  instruction[14:12]
valid_i  input  1  instruction on the bus is live this cycle
rs1_data_i  input  XLEN  register-file read port 1
rs2_data_i  input  XLEN  register-file read port 2
ALU_Operation_o  output  4  ALU op code
md_stall_o  output  1  freeze PC and register-file write
md_done_o  output  1  one-cycle pulse: md_result_o valid, write back
md_result_o  output  XLEN  multiply/divide result
result_sel_o  output  1  1 = write-back mux selects md_result_o

Behaviour:
- ALU decode is combinational, same cycle.
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, LUI 0101, SRL 0110, SLL 0111, SRA 1000, SLT 1001, SLTU 1010.
- R-type (000): funct7=0000000 with funct3 000/111/110/100/101/001/010/011 gives ADD/AND/OR/XOR/SRL/SLL/SLT/SLTU. funct7=0100000 with funct3 000 gives SUB; with 101 gives SRA.
- I-type (001): funct7 is ignored except on shifts. funct3 000/111/110/100/010/011 gives ADDI/ANDI/ORI/XORI/SLTI/SLTIU. funct3 001 with funct7=0000000 gives SLLI. funct3 101 with funct7 0000000 gives SRLI; with 0100000 gives SRAI.
- U-type (100): LUI regardless of funct3/funct7.
- Any other combination gives ADD.
- M op: ALU_Op_i=000 and funct7_i=0000001. funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: on valid_i & M op, capture operands, funct3 and operand signs, then go to MUL or DIV. Special case: DIV/DIVU/REM/REMU with rs2=0, or signed overflow, go straight to DONE.
- Operands are converted to magnitudes per the signedness of the op. A result sign fix-up is applied in the cycle entering DONE.
- MUL: radix-2 shift-add, one bit per cycle, XLEN cycles, 2*XLEN product. Low half goes to MUL; high half goes to MULH/MULHSU/MULHU.
- DIV: restoring division, one bit per cycle, XLEN cycles.
- DONE: md_done_o=1 and result_sel_o=1 for one cycle, then unconditionally return to IDLE.
- valid_i held high in DONE (same instruction) does not restart the sequencer.
- md_stall_o = (IDLE & valid_i & M op) | MUL | DIV. It is combinational, so stall asserts in the decode cycle and is low in DONE.
- Latency from acceptance to md_done_o: XLEN+1 cycles for normal ops, 1 cycle for special cases.
- Back-to-back M ops: the second is accepted in the IDLE cycle after DONE.
- Divide by zero: quotient all ones, remainder = dividend.
- Overflow (rs1=-2^(XLEN-1), rs2=-1, signed): quotient = rs1, remainder 0.
- valid_i low, or a non-M instruction: no state change, stall 0.
- Operand changes during MUL/DIV are ignored.
- reset (synchronous) has priority over everything, including mid-operation: go to IDLE, clear all registers.
- Reset values: md_done_o=0, md_result_o=0, result_sel_o=0. md_stall_o=0 unless IDLE-decode conditions hold after reset.
- ALU_Operation_o is purely combinational and never reset-dependent.

Decomposition:
- Shared package: ALU op-code constants, ALU_Op class constants, M funct3 constants, FSM state encoding. These are shared with the ALU and the control unit.
- One sub-module: md_iter_unit (operand capture, shift-add/restoring datapath, counter, sign fix-up). Top-level alu_md_control holds the decode table and stall/select logic.

Test Plan:
- Decode sweep: every legal R/I/U combination gives the code in the table. ALU_Op=000, funct7=0100000, funct3=111 gives 0000 (default ADD).
- MUL: rs1=7, rs2=-3, funct3=000. md_stall_o is 1 in the decode cycle. md_done_o pulses after 33 cycles, result 0xFFFFFFEB. Stall is low in the done cycle.
- MULH/MULHU: rs1=rs2=0x80000000. MULH gives 0x40000000; MULHU gives 0x40000000. MULHSU with rs1=-1, rs2=2 gives 0xFFFFFFFF.
- Divide by zero and overflow:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REM 5/0 gives 5.
  - DIV 0x80000000/-1 gives 0x80000000.
  - REM 0x80000000/-1 gives 0.
  - Each takes 1-cycle latency.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives -1. Back-to-back MUL then DIV with valid_i held: exactly one done per instruction, no restart in DONE.
- Reset asserted at cycle 10 of a MUL: next cycle IDLE, md_done_o never pulses, md_result_o=0. Next M op completes normally.
